// File: rtl/vec_mem_sequencer_if.sv
// Handshake/bus bundle between the vector sequencer and its environment.
// Optional VSEQ_SCALAR_B_EN adds the scalar_b (broadcast B operand) request line.
interface vec_mem_sequencer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 8
);
    logic              start;
    logic [DATA_W-1:0] src_a_base;
    logic [DATA_W-1:0] src_b_base;
    logic [DATA_W-1:0] dst_base;
    logic [LEN_W-1:0]  vlen;
`ifdef VSEQ_SCALAR_B_EN
    logic              scalar_b;
`endif
    logic              busy;
    logic              done;
    logic [1:0]        addr_sel;
    logic [DATA_W-1:0] ptr_a;
    logic [DATA_W-1:0] ptr_b;
    logic [DATA_W-1:0] ptr_d;
    logic              ld_a;
    logic              ld_b;
    logic              mem_we;
    logic [LEN_W-1:0]  elem_idx;

    modport master (
`ifdef VSEQ_SCALAR_B_EN
        output scalar_b,
`endif
        output start, src_a_base, src_b_base, dst_base, vlen,
        input  busy, done, addr_sel, ptr_a, ptr_b, ptr_d,
        input  ld_a, ld_b, mem_we, elem_idx
    );

    modport slave (
`ifdef VSEQ_SCALAR_B_EN
        input  scalar_b,
`endif
        input  start, src_a_base, src_b_base, dst_base, vlen,
        output busy, done, addr_sel, ptr_a, ptr_b, ptr_d,
        output ld_a, ld_b, mem_we, elem_idx
    );
endinterface

// File: rtl/vec_mem_sequencer.sv
// Memory-to-memory vector op sequencer: RD_A, RD_B, WAIT_B, WR per element.
// Optional VSEQ_SCALAR_B_EN: scalar_b sampled with start freezes ptr_b (B broadcast).
module vec_mem_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 8
) (
    input logic                  clk,
    input logic                  reset,
    vec_mem_sequencer_if.slave   bus
);
    localparam int unsigned FLAG_W = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_A   = 3'd1,
        RD_B   = 3'd2,
        WAIT_B = 3'd3,
        WR     = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] ptr_a_q;
    logic [DATA_W-1:0] ptr_b_q;
    logic [DATA_W-1:0] ptr_d_q;
    logic [LEN_W-1:0]  vlen_q;
    logic [LEN_W-1:0]  idx_q;
    logic              scalar_q;
    logic              busy_q;
    logic              done_q;
    logic [1:0]        sel_q;
    logic              ld_a_q;
    logic              ld_b_q;
    logic              we_q;

    // Output flags of the state being entered: {busy, done, addr_sel, ld_a, ld_b, mem_we}
    function automatic logic [FLAG_W-1:0] decode(state_t s);
        logic [FLAG_W-1:0] f;
        f = '0;
        case (s)
            RD_A:    f = 7'b1_0_01_0_0_0;
            RD_B:    f = 7'b1_0_10_1_0_0;
            WAIT_B:  f = 7'b1_0_10_0_1_0;
            WR:      f = 7'b1_0_11_0_0_1;
            DONE:    f = 7'b1_1_00_0_0_0;
            default: f = '0;
        endcase
        return f;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr_a_q  <= '0;
            ptr_b_q  <= '0;
            ptr_d_q  <= '0;
            vlen_q   <= '0;
            idx_q    <= '0;
            scalar_q <= 1'b0;
            {busy_q, done_q, sel_q, ld_a_q, ld_b_q, we_q} <= decode(IDLE);
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ptr_a_q <= bus.src_a_base;
                        ptr_b_q <= bus.src_b_base;
                        ptr_d_q <= bus.dst_base;
                        vlen_q  <= bus.vlen;
                        idx_q   <= '0;
`ifdef VSEQ_SCALAR_B_EN
                        scalar_q <= bus.scalar_b;
`else
                        scalar_q <= 1'b0;
`endif
                        if (bus.vlen != '0) begin
                            state <= RD_A;
                            {busy_q, done_q, sel_q, ld_a_q, ld_b_q, we_q} <= decode(RD_A);
                        end else begin
                            state <= DONE;
                            {busy_q, done_q, sel_q, ld_a_q, ld_b_q, we_q} <= decode(DONE);
                        end
                    end
                end
                RD_A: begin
                    state <= RD_B;
                    {busy_q, done_q, sel_q, ld_a_q, ld_b_q, we_q} <= decode(RD_B);
                end
                RD_B: begin
                    state <= WAIT_B;
                    {busy_q, done_q, sel_q, ld_a_q, ld_b_q, we_q} <= decode(WAIT_B);
                end
                WAIT_B: begin
                    state <= WR;
                    {busy_q, done_q, sel_q, ld_a_q, ld_b_q, we_q} <= decode(WR);
                end
                WR: begin
                    // Pointers advance on every element exit, wrapping at 2^DATA_W
                    ptr_a_q <= ptr_a_q + DATA_W'(1);
                    ptr_d_q <= ptr_d_q + DATA_W'(1);
                    if (!scalar_q) begin
                        ptr_b_q <= ptr_b_q + DATA_W'(1);
                    end
                    if (idx_q == vlen_q - LEN_W'(1)) begin
                        state <= DONE;
                        {busy_q, done_q, sel_q, ld_a_q, ld_b_q, we_q} <= decode(DONE);
                    end else begin
                        idx_q <= idx_q + LEN_W'(1);
                        state <= RD_A;
                        {busy_q, done_q, sel_q, ld_a_q, ld_b_q, we_q} <= decode(RD_A);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    {busy_q, done_q, sel_q, ld_a_q, ld_b_q, we_q} <= decode(IDLE);
                end
                default: begin
                    state <= IDLE;
                    {busy_q, done_q, sel_q, ld_a_q, ld_b_q, we_q} <= decode(IDLE);
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.addr_sel = sel_q;
    assign bus.ptr_a    = ptr_a_q;
    assign bus.ptr_b    = ptr_b_q;
    assign bus.ptr_d    = ptr_d_q;
    assign bus.ld_a     = ld_a_q;
    assign bus.ld_b     = ld_b_q;
    assign bus.mem_we   = we_q;
    assign bus.elem_idx = idx_q;
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer: per-cycle scoreboard of expected outputs.
module tb_vec_mem_sequencer;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LEN_W  = 8;
`ifdef VSEQ_SCALAR_B_EN
    localparam bit SCALAR_EN = 1'b1;
`else
    localparam bit SCALAR_EN = 1'b0;
`endif

    typedef struct {
        int               cyc;
        logic             busy;
        logic             done;
        logic [1:0]       sel;
        logic             lda;
        logic             ldb;
        logic             we;
        logic [DATA_W-1:0] ptr;
        logic [LEN_W-1:0]  idx;
    } exp_t;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] d;
        logic [LEN_W-1:0]  vlen;
        logic              scalar;
        logic [DATA_W-1:0] exp_a;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t mon_e;

    vec_mem_sequencer_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    vec_mem_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t mk(input int c, input logic [1:0] sel, input logic lda, input logic ldb,
                                input logic we, input logic dn, input logic [DATA_W-1:0] p,
                                input logic [LEN_W-1:0] ix);
        exp_t e;
        e.cyc = c; e.busy = 1'b1; e.done = dn; e.sel = sel;
        e.lda = lda; e.ldb = ldb; e.we = we; e.ptr = p; e.idx = ix;
        return e;
    endfunction

    // Expected cycle-by-cycle behaviour of one op accepted at edge k
    task automatic push_op(input vec_t v, input int k);
        logic [DATA_W-1:0] pa, pb, pd;
        int c;
        pa = v.a; pb = v.b; pd = v.d; c = k;
        for (int e = 0; e < int'(v.vlen); e++) begin
            q.push_back(mk(c,     2'd1, 1'b0, 1'b0, 1'b0, 1'b0, pa, LEN_W'(e)));
            q.push_back(mk(c + 1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, pb, LEN_W'(e)));
            q.push_back(mk(c + 2, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, pb, LEN_W'(e)));
            q.push_back(mk(c + 3, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, pd, LEN_W'(e)));
            pa = pa + DATA_W'(1);
            pd = pd + DATA_W'(1);
            if (!(SCALAR_EN && v.scalar)) pb = pb + DATA_W'(1);
            c += 4;
        end
        q.push_back(mk(c, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0));
    endtask

    // Monitor: sample just after each active edge
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("cycle", 32'(cyc), 32'(mon_e.cyc));
            check("ctl", 32'({bus.busy, bus.done, bus.addr_sel, bus.ld_a, bus.ld_b, bus.mem_we}),
                  32'({mon_e.busy, mon_e.done, mon_e.sel, mon_e.lda, mon_e.ldb, mon_e.we}));
            if (mon_e.sel == 2'd1) check("ptr_a", 32'(bus.ptr_a), 32'(mon_e.ptr));
            if (mon_e.sel == 2'd2) check("ptr_b", 32'(bus.ptr_b), 32'(mon_e.ptr));
            if (mon_e.sel == 2'd3) check("ptr_d", 32'(bus.ptr_d), 32'(mon_e.ptr));
            if (!mon_e.done) check("elem_idx", 32'(bus.elem_idx), 32'(mon_e.idx));
        end else begin
            check("idle", 32'({bus.busy, bus.done, bus.addr_sel, bus.ld_a, bus.ld_b, bus.mem_we}), 32'd0);
        end
    end

    task automatic drive_start(input vec_t v);
        bus.src_a_base = v.a;
        bus.src_b_base = v.b;
        bus.dst_base   = v.d;
        bus.vlen       = v.vlen;
`ifdef VSEQ_SCALAR_B_EN
        bus.scalar_b   = v.scalar;
`endif
        bus.start      = 1'b1;
    endtask

    vec_t vecs[6];
    vec_t mid;

    initial begin
        bus.start = 1'b0;
        bus.src_a_base = '0;
        bus.src_b_base = '0;
        bus.dst_base = '0;
        bus.vlen = '0;
`ifdef VSEQ_SCALAR_B_EN
        bus.scalar_b = 1'b0;
`endif
        vecs[0] = '{a: 16'h0100, b: 16'h0200, d: 16'h0300, vlen: 8'd3,   scalar: 1'b0, exp_a: 16'h0103};
        vecs[1] = '{a: 16'h0500, b: 16'h0600, d: 16'h0700, vlen: 8'd0,   scalar: 1'b0, exp_a: 16'h0500};
        vecs[2] = '{a: 16'hFFFF, b: 16'h0010, d: 16'hFFFE, vlen: 8'd2,   scalar: 1'b0, exp_a: 16'h0001};
        vecs[3] = '{a: 16'h1234, b: 16'hABCD, d: 16'h8000, vlen: 8'd1,   scalar: 1'b0, exp_a: 16'h1235};
        vecs[4] = '{a: 16'h0000, b: 16'h0200, d: 16'h0900, vlen: 8'd4,   scalar: 1'b1, exp_a: 16'h0004};
        vecs[5] = '{a: 16'hFF80, b: 16'h4000, d: 16'h2000, vlen: 8'd255, scalar: 1'b0, exp_a: 16'h007F};

        repeat (3) @(negedge clk);
        check("rst_ptrs", 32'({bus.ptr_a, bus.ptr_b}), 32'd0);
        check("rst_idx", 32'({bus.ptr_d, bus.elem_idx}), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            drive_start(vecs[i]);
            push_op(vecs[i], cyc + 1);
            @(negedge clk);
            bus.start = 1'b0;
            repeat (4 * int'(vecs[i].vlen) + 3) @(negedge clk);
            check("drain", 32'(q.size()), 32'd0);
            check("final_ptr_a", 32'(bus.ptr_a), 32'(vecs[i].exp_a));
            check("final_ptr_d", 32'(bus.ptr_d), 32'(DATA_W'(vecs[i].d + DATA_W'(vecs[i].vlen))));
            check("final_ptr_b", 32'(bus.ptr_b),
                  32'((SCALAR_EN && vecs[i].scalar) ? vecs[i].b : DATA_W'(vecs[i].b + DATA_W'(vecs[i].vlen))));
        end

        // Second start mid-op is ignored; reset during WR of element 1 aborts the op
        mid = '{a: 16'h0400, b: 16'h0500, d: 16'h0600, vlen: 8'd3, scalar: 1'b0, exp_a: 16'h0000};
        drive_start(mid);
        push_op(mid, cyc + 1);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        drive_start('{a: 16'h7000, b: 16'h7100, d: 16'h7200, vlen: 8'd9, scalar: 1'b0, exp_a: 16'h0000});
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_in_wr", 32'({bus.mem_we, bus.elem_idx}), 32'({1'b1, 8'd1}));
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        check("rst_we", 32'({bus.mem_we, bus.busy}), 32'd0);
        check("rst_ptr_d", 32'(bus.ptr_d), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
